// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed driver for DIGITS common-anode 7-segment
// digits sharing one set of segment lines. A packed hex value, decimal-point
// mask and blank mask are captured on load and scanned out one digit per slot.
// Each slot opens with a one-cycle dark gap (anti-ghosting), then drives the
// digit for REFRESH_DIV-1 cycles.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   Defined: a digit above digit 0 goes dark when it and every digit above it
//   hold zero (blank_mask still applies).
//   Undefined: only blank_mask darkens digits.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   load         in   capture value/dp_mask/blank_mask into shadow registers
//   value        in   4*DIGITS packed nibbles, digit 0 rightmost
//   dp_mask      in   DIGITS, 1 = decimal point lit
//   blank_mask   in   DIGITS, 1 = digit forced dark
//   seg          out  [0:6] segments a..g, active low, seg[0] = a
//   dp           out  decimal point, active low
//   an           out  DIGITS digit enables, active low
//   frame_start  out  one-cycle pulse on the first drive cycle of digit 0
module hex_scan_display #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [0:6]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   sv_q;
    logic [DIGITS-1:0]     sdp_q;
    logic [DIGITS-1:0]     sbl_q;

    logic [0:6]            seg_d;
    logic                  dp_d;
    logic [DIGITS-1:0]     an_d;
    logic                  frame_start_d;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_bl;
    logic                  lz_blank;
    logic                  blank_now;

    // Active-low hex to 7-segment decode, a..g left to right.
    function automatic logic [0:6] hex_decode(input logic [3:0] nib);
        logic [0:6] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Shadow registers: only load changes them.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sv_q  <= '0;
            sdp_q <= '0;
            sbl_q <= '0;
        end else if (load) begin
            sv_q  <= value;
            sdp_q <= dp_mask;
            sbl_q <= blank_mask;
        end
    end

    // Select the current digit's shadow data.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_bl  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = sv_q[4*i +: 4];
                cur_dp  = sdp_q[i];
                cur_bl  = sbl_q[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Dark when this digit and all digits above it are zero; digit 0 always shows.
    always_comb begin
        logic upper_nz;
        upper_nz = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((IDX_W'(i) >= idx_q) && (sv_q[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = (idx_q != '0) && !upper_nz;
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign blank_now = cur_bl | lz_blank;

    // State, counter and output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= GAP;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg         <= seg_d;
            dp          <= dp_d;
            an          <= an_d;
            frame_start <= frame_start_d;
        end
    end

    // Next state and next outputs. Outputs follow the current state one cycle
    // later; digit data is latched into the output registers on the first
    // drive cycle and held for the rest of the slot.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        seg_d         = seg;
        dp_d          = dp;
        an_d          = an;
        frame_start_d = 1'b0;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            GAP: begin
                seg_d   = 7'b1111111;
                dp_d    = 1'b1;
                an_d    = '1;
                state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == CNT_FIRST) begin
                    frame_start_d = (idx_q == '0);
                    if (blank_now) begin
                        seg_d = 7'b1111111;
                        dp_d  = 1'b1;
                        an_d  = '1;
                    end else begin
                        seg_d = hex_decode(cur_nib);
                        dp_d  = ~cur_dp;
                        an_d  = ~(DIGITS'(1) << idx_q);
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = GAP;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with DIGITS=4, REFRESH_DIV=4 (16-cycle
// frame). Each frame is compared cycle by cycle against a per-digit table of
// hand-decoded segment patterns.
module tb_hex_scan_display;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned RDIV   = 4;
    localparam int unsigned FRAME  = DIGITS * RDIV;

    localparam logic [0:6] S0   = 7'b0000001;
    localparam logic [0:6] S1   = 7'b1001111;
    localparam logic [0:6] S2   = 7'b0010010;
    localparam logic [0:6] S3   = 7'b0000110;
    localparam logic [0:6] S4   = 7'b1001100;
    localparam logic [0:6] S5   = 7'b0100100;
    localparam logic [0:6] SA   = 7'b0001000;
    localparam logic [0:6] SB   = 7'b1100000;
    localparam logic [0:6] SC   = 7'b0110001;
    localparam logic [0:6] SD   = 7'b1000010;
    localparam logic [0:6] SF   = 7'b0111000;
    localparam logic [12:0] DARK = {4'hF, 7'b1111111, 1'b1, 1'b0};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] ZERO_LIT = 4'b0001;
    localparam logic [3:0] H50_LIT  = 4'b0011;
`else
    localparam logic [3:0] ZERO_LIT = 4'b1111;
    localparam logic [3:0] H50_LIT  = 4'b1111;
`endif

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_mask = '0;
    logic [3:0]    blank_mask = '0;
    logic [0:6]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_start;

    int vectors = 0;
    int miscompares = 0;

    logic [0:6] exp_seg [4];
    logic       exp_dpm [4];
    logic       exp_lit [4];

    hex_scan_display #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got an/seg/dp/fs=%b want %b", tag, got, exp);
        end
    endtask

    // segs packed {d3,d2,d1,d0}
    task automatic set_table(input logic [27:0] segs, input logic [3:0] dpm, input logic [3:0] lit);
        for (int i = 0; i < 4; i++) begin
            exp_seg[i] = segs[7*i +: 7];
            exp_dpm[i] = dpm[i];
            exp_lit[i] = lit[i];
        end
    endtask

    // Offset k counts from the frame_start cycle; k%4==3 is the next slot's gap.
    task automatic check_cycle(input int k, input string tag);
        logic [12:0] e;
        logic [3:0]  an_e;
        int p;
        int d;
        p = k % 4;
        d = k / 4;
        if (p == 3 || !exp_lit[d]) begin
            e = DARK;
        end else begin
            an_e = ~(4'b0001 << d);
            e = {an_e, exp_seg[d], ~exp_dpm[d], 1'b0};
        end
        if (k == 0) e[0] = 1'b1;
        check(tag, {an, seg, dp, frame_start}, e);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 3 * int'(FRAME)) begin
            @(negedge Clock);
            n++;
        end
        if (frame_start !== 1'b1) check("frame_start_timeout", {12'b0, frame_start}, 13'd1);
    endtask

    task automatic check_frame(input string name);
        wait_frame();
        for (int k = 0; k < int'(FRAME); k++) begin
            check_cycle(k, $sformatf("%s_c%0d", name, k));
            @(negedge Clock);
        end
        check($sformatf("%s_period", name), {12'b0, frame_start}, 13'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blm);
        value      = v;
        dp_mask    = dpm;
        blank_mask = blm;
        load       = 1'b1;
        @(negedge Clock);
        load = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first frame after release
        @(negedge Clock);
        @(negedge Clock);
        check("reset_state", {an, seg, dp, frame_start}, DARK);
        Resetn = 1'b1;
        @(negedge Clock);
        check("first_gap", {an, seg, dp, frame_start}, DARK);
        @(negedge Clock);
        check("first_drive", {an, seg, dp, frame_start}, {4'b1110, S0, 1'b1, 1'b1});
        set_table({S0, S0, S0, S0}, 4'b0000, ZERO_LIT);
        check_frame("zero");

        // Plain digits
        do_load(16'h1234, 4'b0000, 4'b0000);
        set_table({S1, S2, S3, S4}, 4'b0000, 4'b1111);
        check_frame("h1234");

        // Letters with decimal points on digits 0 and 2
        do_load(16'hABCD, 4'b0101, 4'b0000);
        set_table({SA, SB, SC, SD}, 4'b0101, 4'b1111);
        check_frame("habcd_dp");

        // Digit 1 blanked; frame length unchanged
        do_load(16'hABCD, 4'b0101, 4'b0010);
        set_table({SA, SB, SC, SD}, 4'b0101, 4'b1101);
        check_frame("blank1");

        // Interior zeros and leading zeros
        do_load(16'h0050, 4'b0000, 4'b0000);
        set_table({S0, S0, S5, S0}, 4'b0000, H50_LIT);
        check_frame("h0050");

        // Back-to-back loads in the middle of digit 2's slot
        do_load(16'h0000, 4'b0000, 4'b0000);
        set_table({S0, S0, S0, S0}, 4'b0000, ZERO_LIT);
        wait_frame();
        for (int k = 0; k <= 8; k++) begin
            check_cycle(k, $sformatf("mid_c%0d", k));
            if (k < 8) @(negedge Clock);
        end
        value = 16'h5555;
        load  = 1'b1;
        @(negedge Clock);
        value = 16'hFFFF;
        check_cycle(9, "mid_c9");
        @(negedge Clock);
        load = 1'b0;
        check_cycle(10, "mid_c10");
        set_table({SF, SF, SF, SF}, 4'b0000, 4'b1111);
        for (int k = 11; k < int'(FRAME); k++) begin
            @(negedge Clock);
            check_cycle(k, $sformatf("mid_c%0d", k));
        end
        @(negedge Clock);
        check("mid_period", {12'b0, frame_start}, 13'd1);
        check_frame("hffff");

        // Asynchronous reset in the middle of digit 1's drive
        wait_frame();
        repeat (5) @(negedge Clock);
        check_cycle(5, "pre_rst_c5");
        #2 Resetn = 1'b0;
        #1 check("async_rst", {an, seg, dp, frame_start}, DARK);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_rst_gap", {an, seg, dp, frame_start}, DARK);
        set_table({S0, S0, S0, S0}, 4'b0000, ZERO_LIT);
        check_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
